// File: rtl/priority_pkg.sv
// rtl/priority_pkg.sv - shared types and constants for the priority bit serializer
package priority_pkg;

   // Serializer control states
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Walk order selectors sampled with each accepted mask
   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/priority_bit_pick.sv
// rtl/priority_bit_pick.sv - combinational one-hot pick of the lowest or highest set bit
module priority_bit_pick
   import priority_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] mask_i,
   input  logic             dir_i,
   output logic [WIDTH-1:0] pick_o
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] mask_rev;
   logic [WIDTH-1:0] lsb_pick;
   logic [WIDTH-1:0] rev_pick;
   logic [WIDTH-1:0] msb_pick;

   // Bit-reverse the mask so the highest set bit becomes the lowest
   always_comb begin
      mask_rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         mask_rev[i] = mask_i[WIDTH-1-i];
      end
   end

   // Isolate the lowest set bit of both views (two's complement trick)
   always_comb begin
      lsb_pick = mask_i & (~mask_i + ONE);
      rev_pick = mask_rev & (~mask_rev + ONE);
   end

   // Reverse the isolated bit back and select by direction
   always_comb begin
      msb_pick = '0;
      for (int i = 0; i < WIDTH; i++) begin
         msb_pick[i] = rev_pick[WIDTH-1-i];
      end
      pick_o = (dir_i == DIR_MSB_FIRST) ? msb_pick : lsb_pick;
   end

endmodule

// File: rtl/priority_bit_serializer.sv
// rtl/priority_bit_serializer.sv - walks every set bit of a mask as one-hot beats (option: PRIORITY_BIT_SERIALIZER_INDEX_OUT_EN)
module priority_bit_serializer
   import priority_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                       clk_i,
   input  logic                       srst_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       dir_i,
   input  logic                       data_val_i,
   output logic                       ready_o,
   output logic [WIDTH-1:0]           data_o,
   output logic                       last_o,
   output logic                       data_val_o,
`ifdef PRIORITY_BIT_SERIALIZER_INDEX_OUT_EN
   output logic [$clog2(WIDTH)-1:0]   idx_o,
   output logic [$clog2(WIDTH+1)-1:0] cnt_o,
`endif
   input  logic                       ready_i
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             last_q, last_d;
   logic             dir_q, dir_d;

   logic             accept;
   logic [WIDTH-1:0] pick_mask;
   logic             pick_dir;
   logic [WIDTH-1:0] pick;
   logic [WIDTH-1:0] rest;

`ifdef PRIORITY_BIT_SERIALIZER_INDEX_OUT_EN
   localparam int IW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH + 1);

   logic [IW-1:0] idx_q, idx_d, pick_idx;
   logic [CW-1:0] cnt_q, cnt_d;

   // Binary position of the one-hot pick (zero when nothing is set)
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pick[i]) pick_idx = IW'(i);
      end
   end

   assign idx_o = idx_q;
   assign cnt_o = cnt_q;
`endif

   // Ready is combinational from ready_i so back-to-back masks leave no gap
   assign ready_o    = (state_q == IDLE) | (last_q & ready_i);
   assign accept     = data_val_i & ready_o;
   assign data_o     = data_q;
   assign last_o     = last_q;
   assign data_val_o = (state_q == BUSY);

   // A freshly accepted mask takes the pick ahead of the remaining mask
   always_comb begin
      pick_mask = accept ? data_i : rem_q;
      pick_dir  = accept ? dir_i  : dir_q;
   end

   priority_bit_pick #(
      .WIDTH (WIDTH)
   ) u_pick (
      .mask_i (pick_mask),
      .dir_i  (pick_dir),
      .pick_o (pick)
   );

   assign rest = pick_mask & ~pick;

   // Next-state and next-beat selection; a stalled beat simply holds
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      data_d  = data_q;
      last_d  = last_q;
      dir_d   = dir_q;
`ifdef PRIORITY_BIT_SERIALIZER_INDEX_OUT_EN
      idx_d   = idx_q;
      cnt_d   = cnt_q;
`endif
      if (accept) begin
         state_d = BUSY;
         dir_d   = dir_i;
         data_d  = pick;
         rem_d   = rest;
         last_d  = (rest == '0);
`ifdef PRIORITY_BIT_SERIALIZER_INDEX_OUT_EN
         idx_d   = pick_idx;
         cnt_d   = '0;
`endif
      end else if ((state_q == BUSY) && ready_i) begin
         if (last_q) begin
            state_d = IDLE;
            data_d  = '0;
            last_d  = 1'b0;
            rem_d   = '0;
`ifdef PRIORITY_BIT_SERIALIZER_INDEX_OUT_EN
            idx_d   = '0;
            cnt_d   = '0;
`endif
         end else begin
            data_d  = pick;
            rem_d   = rest;
            last_d  = (rest == '0);
`ifdef PRIORITY_BIT_SERIALIZER_INDEX_OUT_EN
            idx_d   = pick_idx;
            cnt_d   = cnt_q + CW'(1);
`endif
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q <= IDLE;
         rem_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         dir_q   <= DIR_LSB_FIRST;
`ifdef PRIORITY_BIT_SERIALIZER_INDEX_OUT_EN
         idx_q   <= '0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         last_q  <= last_d;
         dir_q   <= dir_d;
`ifdef PRIORITY_BIT_SERIALIZER_INDEX_OUT_EN
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_priority_bit_serializer.sv
// tb/tb_priority_bit_serializer.sv - scoreboard bench for priority_bit_serializer
module tb_priority_bit_serializer;

   logic        clk_i;
   logic        srst_i;
   logic [15:0] data_i;
   logic        dir_i;
   logic        data_val_i;
   logic        ready_o;
   logic [15:0] data_o;
   logic        last_o;
   logic        data_val_o;
   logic        ready_i;
`ifdef PRIORITY_BIT_SERIALIZER_INDEX_OUT_EN
   logic [3:0]  idx_o;
   logic [4:0]  cnt_o;
`endif

   priority_bit_serializer #(.WIDTH(16)) dut (
      .clk_i      (clk_i),
      .srst_i     (srst_i),
      .data_i     (data_i),
      .dir_i      (dir_i),
      .data_val_i (data_val_i),
      .ready_o    (ready_o),
      .data_o     (data_o),
      .last_o     (last_o),
      .data_val_o (data_val_o),
`ifdef PRIORITY_BIT_SERIALIZER_INDEX_OUT_EN
      .idx_o      (idx_o),
      .cnt_o      (cnt_o),
`endif
      .ready_i    (ready_i)
   );

   typedef struct {
      logic [15:0] d;
      logic        l;
      int          idx;
      int          cnt;
   } beat_t;

   beat_t exp_q[$];
   int    total = 0;
   int    bad   = 0;
   bit    toggle_en = 0;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Optional downstream back-pressure pattern
   initial begin
      forever begin
         @(posedge clk_i);
         #2;
         if (toggle_en) ready_i = ~ready_i;
      end
   end

   // Monitor: compare every presented beat with the scoreboard head
   always @(negedge clk_i) begin : monitor
      beat_t e;
      if (!srst_i && data_val_o) begin
         if (exp_q.size() == 0) begin
            if (ready_i) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat data_o=%h last_o=%b", data_o, last_o);
            end
         end else begin
            e = exp_q[0];
            total++;
            if (data_o !== e.d || last_o !== e.l) begin
               bad++;
               $display("FAIL beat got data=%h last=%b want data=%h last=%b", data_o, last_o, e.d, e.l);
            end
`ifdef PRIORITY_BIT_SERIALIZER_INDEX_OUT_EN
            total++;
            if (int'(idx_o) != e.idx || int'(cnt_o) != e.cnt) begin
               bad++;
               $display("FAIL index got idx=%0d cnt=%0d want idx=%0d cnt=%0d", idx_o, cnt_o, e.idx, e.cnt);
            end
`endif
            if (ready_i) void'(exp_q.pop_front());
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, want);
      end
   endtask

   task automatic push(input logic [15:0] d, input logic l, input int idx, input int cnt);
      beat_t b;
      b.d = d; b.l = l; b.idx = idx; b.cnt = cnt;
      exp_q.push_back(b);
   endtask

   // Present a mask until accepted; returns at posedge+1 after the accept edge
   task automatic send(input logic [15:0] d, input logic dr, input bit keep, output int waits);
      bit ok;
      data_i = d;
      dir_i = dr;
      data_val_i = 1'b1;
      waits = 0;
      do begin
         @(negedge clk_i);
         ok = ready_o;
         @(posedge clk_i);
         #1;
         waits++;
      end while (!ok && waits < 200);
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL accept_timeout mask=%h", d);
      end
      if (!keep) data_val_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || data_val_o) && n < 300) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL drain_timeout pending=%0d", exp_q.size());
      end
   endtask

   initial begin
      int w;
      int n;
      srst_i = 1'b1;
      data_i = '0;
      dir_i = 1'b0;
      data_val_i = 1'b0;
      ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      srst_i = 1'b0;

      @(negedge clk_i);
      chk("rst_val", 32'(data_val_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_data", 32'(data_o), 32'd0);
      chk("rst_last", 32'(last_o), 32'd0);
      @(posedge clk_i);
      #1;

      // LSB-first walk, first beat one cycle after accept
      push(16'h0001, 1'b0, 0, 0);
      push(16'h0004, 1'b0, 2, 1);
      push(16'h2000, 1'b0, 13, 2);
      push(16'h8000, 1'b1, 15, 3);
      send(16'hA005, 1'b0, 1'b0, w);
      @(negedge clk_i);
      chk("first_beat_val", 32'(data_val_o), 32'd1);
      chk("first_beat_data", 32'(data_o), 32'h0001);
      @(posedge clk_i);
      #1;
      drain();

      // MSB-first walk
      push(16'h8000, 1'b0, 15, 0);
      push(16'h2000, 1'b0, 13, 1);
      push(16'h0004, 1'b0, 2, 2);
      push(16'h0001, 1'b1, 0, 3);
      send(16'hA005, 1'b1, 1'b0, w);
      drain();

      // Zero mask: one empty last beat, ready in its transfer cycle
      push(16'h0000, 1'b1, 0, 0);
      send(16'h0000, 1'b0, 1'b0, w);
      @(negedge clk_i);
      chk("zero_ready", 32'(ready_o), 32'd1);
      @(posedge clk_i);
      #1;
      drain();

      // Stalls from a toggling downstream ready
      push(16'h0002, 1'b0, 1, 0);
      push(16'h0004, 1'b1, 2, 1);
      toggle_en = 1;
      send(16'h0006, 1'b0, 1'b0, w);
      drain();
      toggle_en = 0;
      ready_i = 1'b1;

      // Back-to-back single-bit masks
      push(16'h0001, 1'b1, 0, 0);
      push(16'h8000, 1'b1, 15, 0);
      send(16'h0001, 1'b0, 1'b1, w);
      send(16'h8000, 1'b0, 1'b0, w);
      chk("b2b_waits", 32'(w), 32'd1);
      @(negedge clk_i);
      chk("b2b_no_gap", 32'(data_val_o), 32'd1);
      @(posedge clk_i);
      #1;
      drain();

      // Reset in the middle of a full mask
      push(16'h8000, 1'b0, 15, 0);
      push(16'h4000, 1'b0, 14, 1);
      push(16'h2000, 1'b0, 13, 2);
      send(16'hFFFF, 1'b1, 1'b0, w);
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      chk("pre_reset_beats", 32'(exp_q.size()), 32'd0);
      srst_i = 1'b1;
      @(posedge clk_i);
      #1;
      srst_i = 1'b0;
      @(negedge clk_i);
      chk("mid_rst_val", 32'(data_val_o), 32'd0);
      chk("mid_rst_ready", 32'(ready_o), 32'd1);
      chk("mid_rst_last", 32'(last_o), 32'd0);
      @(posedge clk_i);
      #1;
      push(16'h0010, 1'b1, 4, 0);
      send(16'h0010, 1'b0, 1'b0, w);
      drain();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
